// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider: mode encoding and default width.
package clk_div_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active scale/mode, registered output.
// Optional tick output is present when CLK_DIV_MULTI_TICK_EN is defined.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_in,
    input  logic             nrst,
    input  logic [WIDTH-1:0] scale,
    input  logic             mode,
    input  logic             enable,
    input  logic             sync,
    output logic             clk_out
`ifdef CLK_DIV_MULTI_TICK_EN
    ,
    output logic             tick
`endif
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] scale_reg, scale_next;
    logic             mode_reg, mode_next;
    logic             run_reg, run_next;
    logic             out_reg, out_next;

    logic restart;
    logic terminal;
    logic boundary;
    logic scale_zero;

    // Idle, disabled or sync all collapse to the same restart: phase zero, output low.
    assign restart    = !enable || sync || !run_reg;
    assign terminal   = (count_reg == scale_reg - ONE);
    assign boundary   = terminal && ((mode_reg == MODE_PULSE) || out_reg);
    assign scale_zero = (scale == '0);

    always_comb begin
        count_next = count_reg;
        scale_next = scale_reg;
        mode_next  = mode_reg;
        run_next   = run_reg;
        out_next   = out_reg;
        if (restart) begin
            count_next = '0;
            out_next   = 1'b0;
            scale_next = scale;
            mode_next  = mode;
            run_next   = enable && !scale_zero;
        end else if (terminal) begin
            count_next = '0;
            if (boundary) begin
                // A pulse is only emitted if the next period is also pulse mode and non-idle,
                // so a switch to toggle always begins with a clean low phase.
                out_next   = (mode_reg == MODE_PULSE) && (mode == MODE_PULSE) && !scale_zero;
                scale_next = scale;
                mode_next  = mode;
                run_next   = !scale_zero;
            end else begin
                out_next = 1'b1;
            end
        end else begin
            count_next = count_reg + ONE;
            if (mode_reg == MODE_PULSE) begin
                out_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            count_reg <= '0;
            scale_reg <= '0;
            mode_reg  <= MODE_TOGGLE;
            run_reg   <= 1'b0;
            out_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            scale_reg <= scale_next;
            mode_reg  <= mode_next;
            run_reg   <= run_next;
            out_reg   <= out_next;
        end
    end

    assign clk_out = out_reg;

`ifdef CLK_DIV_MULTI_TICK_EN
    logic tick_reg;

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= !restart && terminal && !(boundary && scale_zero);
        end
    end

    assign tick = tick_reg;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// CHANNELS independent clock dividers sharing one clock and one sync strobe.
// Define CLK_DIV_MULTI_TICK_EN to add a per-channel terminal-count tick output.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = 2
) (
    input  logic                      clk_in,
    input  logic                      nrst,
    input  logic [CHANNELS*WIDTH-1:0] scale,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       enable,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       clk_out
`ifdef CLK_DIV_MULTI_TICK_EN
    ,
    output logic [CHANNELS-1:0]       tick
`endif
);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_channel
            clk_div_channel #(
                .WIDTH(WIDTH)
            ) u_channel (
                .clk_in (clk_in),
                .nrst   (nrst),
                .scale  (scale[gi*WIDTH +: WIDTH]),
                .mode   (mode[gi]),
                .enable (enable[gi]),
                .sync   (sync),
                .clk_out(clk_out[gi])
`ifdef CLK_DIV_MULTI_TICK_EN
                ,
                .tick   (tick[gi])
`endif
            );
        end
    endgenerate

endmodule
